// File: rtl/datapath_exerciser.sv
// Register-file/ALU exerciser: a FIFO of control words executed by a LOAD/EXEC/WB sequencer.
// Build option: define DATAPATH_EXERCISER_R0_ZERO_EN to hardwire R0 to zero.
//
// state | meaning
// IDLE  | waiting for step or run with a non-empty queue
// LOAD  | pop the queue head into cur_cw
// EXEC  | read operands, evaluate the ALU, register buses and status
// WB    | write back, count the retired word, chain to LOAD while running
module datapath_exerciser #(
  parameter int WIDTH      = 16,
  parameter int REG_COUNT  = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int AW        = $clog2(REG_COUNT),
  localparam int CWW       = 6 + 3 * AW
) (
  input  logic                       clock_i,
  input  logic                       reset_ni,
  input  logic [CWW-1:0]             cw_in_i,
  input  logic                       cw_push_i,
  input  logic                       step_i,
  input  logic                       run_i,
  output logic                       cw_full_o,
  output logic                       cw_empty_o,
  output logic                       cw_overflow_o,
  output logic                       busy_o,
  output logic [CWW-1:0]             cur_cw_o,
  output logic [WIDTH-1:0]           a_bus_o,
  output logic [WIDTH-1:0]           b_bus_o,
  output logic [WIDTH-1:0]           f_bus_o,
  output logic [3:0]                 status_o,
  output logic [REG_COUNT*WIDTH-1:0] regs_flat_o,
  output logic [15:0]                retired_o
);

  localparam int FW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXEC, S_WB} state_t;

  state_t state_q, state_d;
  logic   pop, exec_en, wb_en;

  logic [CWW-1:0] fifo_q [FIFO_DEPTH];
  logic [FW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FW:0]    count_q, count_d;
  logic           full_q, empty_q, ovf_q;
  logic           push_ok;

  logic [WIDTH-1:0] regs_q [REG_COUNT];
  logic [CWW-1:0]   cur_cw_q;
  logic [WIDTH-1:0] a_bus_q, b_bus_q, f_bus_q;
  logic [3:0]       status_q;
  logic [15:0]      retired_q;

  logic [4:0]    fs;
  logic          wr;
  logic [AW-1:0] da, sa, sb;
  logic          wr_en;

  logic [WIDTH-1:0] op_a, op_b, add_b, alu_f;
  logic [WIDTH:0]   sum;
  logic             add_en, add_cin, alu_c, alu_v;

  assign fs = cur_cw_q[CWW-1 -: 5];
  assign wr = cur_cw_q[3*AW];
  assign da = cur_cw_q[3*AW-1 -: AW];
  assign sa = cur_cw_q[2*AW-1 -: AW];
  assign sb = cur_cw_q[AW-1:0];

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    exec_en = 1'b0;
    wb_en   = 1'b0;
    unique case (state_q)
      S_IDLE: if ((step_i || run_i) && !empty_q) state_d = S_LOAD;
      S_LOAD: begin
        pop     = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        exec_en = 1'b1;
        state_d = S_WB;
      end
      S_WB: begin
        wb_en   = 1'b1;
        state_d = (run_i && !empty_q) ? S_LOAD : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // A full queue still accepts a push on the edge that pops its head.
  assign push_ok = cw_push_i && (!full_q || pop);

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop)      count_d = count_q + (FW+1)'(1);
    else if (!push_ok && pop) count_d = count_q - (FW+1)'(1);
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) begin
        fifo_q[wr_ptr_q] <= cw_in_i;
        wr_ptr_q         <= wr_ptr_q + FW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + FW'(1);
      if (cw_push_i && !push_ok) ovf_q <= 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == (FW+1)'(FIFO_DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  assign op_a = regs_q[sa];
  assign op_b = regs_q[sb];

  always_comb begin
    alu_f   = op_b;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    add_en  = 1'b0;
    add_b   = '0;
    add_cin = 1'b0;
    case (fs)
      5'd0:  alu_f = op_a;
      5'd1:  begin add_en = 1'b1; add_cin = 1'b1; end
      5'd2:  begin add_en = 1'b1; add_b = op_b; end
      5'd3:  begin add_en = 1'b1; add_b = ~op_b; add_cin = 1'b1; end
      5'd4:  alu_f = op_a & op_b;
      5'd5:  alu_f = op_a | op_b;
      5'd6:  alu_f = op_a ^ op_b;
      5'd7:  alu_f = ~op_a;
      5'd8:  begin alu_f = {op_b[WIDTH-2:0], 1'b0}; alu_c = op_b[WIDTH-1]; end
      5'd9:  begin alu_f = {1'b0, op_b[WIDTH-1:1]}; alu_c = op_b[0]; end
      5'd31: alu_f = WIDTH'({sa, sb});
      default: alu_f = op_b;
    endcase
    sum = {1'b0, op_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    if (add_en) begin
      alu_f = sum[WIDTH-1:0];
      alu_c = sum[WIDTH];
      alu_v = (op_a[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
    end
  end

`ifdef DATAPATH_EXERCISER_R0_ZERO_EN
  assign wr_en = wb_en && wr && (da != '0);
`else
  assign wr_en = wb_en && wr;
`endif

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
      cur_cw_q  <= '0;
      a_bus_q   <= '0;
      b_bus_q   <= '0;
      f_bus_q   <= '0;
      status_q  <= '0;
      retired_q <= '0;
    end else begin
      if (pop) cur_cw_q <= fifo_q[rd_ptr_q];
      if (exec_en) begin
        a_bus_q  <= op_a;
        b_bus_q  <= op_b;
        f_bus_q  <= alu_f;
        status_q <= {alu_v, alu_c, alu_f[WIDTH-1], (alu_f == '0)};
      end
      if (wr_en) regs_q[da] <= f_bus_q;
      if (wb_en) retired_q <= retired_q + 16'd1;
    end
  end

  always_comb begin
    regs_flat_o = '0;
    for (int i = 0; i < REG_COUNT; i++) regs_flat_o[i*WIDTH +: WIDTH] = regs_q[i];
  end

  assign cw_full_o     = full_q;
  assign cw_empty_o    = empty_q;
  assign cw_overflow_o = ovf_q;
  assign busy_o        = (state_q != S_IDLE);
  assign cur_cw_o      = cur_cw_q;
  assign a_bus_o       = a_bus_q;
  assign b_bus_o       = b_bus_q;
  assign f_bus_o       = f_bus_q;
  assign status_o      = status_q;
  assign retired_o     = retired_q;

endmodule

// File: tb/tb_datapath_exerciser.sv
// Directed bench for datapath_exerciser: queue-level reference model compared every cycle,
// plus literal expectations taken from worked examples.
module tb_datapath_exerciser;

  localparam int W   = 16;
  localparam int RC  = 8;
  localparam int FD  = 4;
  localparam int CWW = 15;

`ifdef DATAPATH_EXERCISER_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic [CWW-1:0] cw_in = '0;
  logic cw_push = 1'b0, step = 1'b0, run = 1'b0;
  logic cw_full, cw_empty, cw_overflow, busy;
  logic [CWW-1:0] cur_cw;
  logic [W-1:0] a_bus, b_bus, f_bus;
  logic [3:0] status;
  logic [RC*W-1:0] regs_flat;
  logic [15:0] retired;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;
  int cyc;

  always #5 clock = ~clock;

  datapath_exerciser #(.WIDTH(W), .REG_COUNT(RC), .FIFO_DEPTH(FD)) dut (
    .clock_i(clock), .reset_ni(reset_n), .cw_in_i(cw_in), .cw_push_i(cw_push),
    .step_i(step), .run_i(run), .cw_full_o(cw_full), .cw_empty_o(cw_empty),
    .cw_overflow_o(cw_overflow), .busy_o(busy), .cur_cw_o(cur_cw),
    .a_bus_o(a_bus), .b_bus_o(b_bus), .f_bus_o(f_bus), .status_o(status),
    .regs_flat_o(regs_flat), .retired_o(retired)
  );

  // Reference model: queue of words plus the word in flight (phase 1..3 = load/exec/writeback due).
  logic [W-1:0]   mregs [RC];
  logic [CWW-1:0] mq [$];
  logic [CWW-1:0] mcur;
  logic [W-1:0]   ma, mb, mf;
  logic [3:0]     mst;
  logic [15:0]    mret;
  logic           movf;
  int             phase;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic lit(input string name, input logic [127:0] act, input logic [127:0] mdl,
                     input logic [127:0] exp);
    check(name, act, exp);
    check({name, "_model"}, mdl, exp);
  endtask

  function automatic logic [W-1:0] dreg(input int i);
    return regs_flat[i*W +: W];
  endfunction

  function automatic logic [127:0] mflat();
    logic [127:0] v = '0;
    for (int i = 0; i < RC; i++) v[i*W +: W] = mregs[i];
    return v;
  endfunction

  function automatic void alu(input logic [4:0] fs, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [5:0] imm, output logic [W-1:0] f, output logic [3:0] st);
    longint ua, ub, sa_v, sb_v, r, sr;
    bit c, v, ar;
    ua = longint'(a);
    ub = longint'(b);
    sa_v = a[W-1] ? ua - 65536 : ua;
    sb_v = b[W-1] ? ub - 65536 : ub;
    c = 1'b0; v = 1'b0; ar = 1'b0; sr = 0;
    case (fs)
      5'd0:  r = ua;
      5'd1:  begin r = ua + 1;            sr = sa_v + 1;    ar = 1'b1; end
      5'd2:  begin r = ua + ub;           sr = sa_v + sb_v; ar = 1'b1; end
      5'd3:  begin r = ua + (65535 - ub) + 1; sr = sa_v - sb_v; ar = 1'b1; end
      5'd4:  r = longint'(a & b);
      5'd5:  r = longint'(a | b);
      5'd6:  r = longint'(a ^ b);
      5'd7:  r = longint'(~a);
      5'd8:  begin r = (ub * 2) % 65536; c = b[W-1]; end
      5'd9:  begin r = ub / 2;           c = b[0];   end
      5'd31: r = longint'(imm);
      default: r = ub;
    endcase
    if (ar) begin
      c = (r > 65535);
      v = (sr > 32767) || (sr < -32768);
    end
    f = r[W-1:0];
    st = {v, c, f[W-1], (f == '0)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < RC; i++) mregs[i] = '0;
    mq.delete();
    mcur = '0; ma = '0; mb = '0; mf = '0; mst = '0; mret = '0; movf = 1'b0; phase = 0;
  endtask

  task automatic model_edge();
    int sz;
    bit popping;
    sz = mq.size();
    popping = (phase == 1);
    case (phase)
      0: if ((step || run) && sz > 0) phase = 1;
      1: begin mcur = mq.pop_front(); phase = 2; end
      2: begin
        ma = mregs[mcur[5:3]];
        mb = mregs[mcur[2:0]];
        alu(mcur[14:10], ma, mb, mcur[5:0], mf, mst);
        phase = 3;
      end
      default: begin
        if (mcur[9] && !(R0Z && mcur[8:6] == 3'd0)) mregs[mcur[8:6]] = mf;
        mret = mret + 16'd1;
        phase = (run && sz > 0) ? 1 : 0;
      end
    endcase
    if (cw_push) begin
      if (sz < FD || popping) mq.push_back(cw_in);
      else movf = 1'b1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) model_reset();
      else          model_edge();
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (cmp_en) begin
        check("cw_empty",    128'(cw_empty),    128'(mq.size() == 0));
        check("cw_full",     128'(cw_full),     128'(mq.size() == FD));
        check("cw_overflow", 128'(cw_overflow), 128'(movf));
        check("busy",        128'(busy),        128'(phase != 0));
        check("cur_cw",      128'(cur_cw),      128'(mcur));
        check("a_bus",       128'(a_bus),       128'(ma));
        check("b_bus",       128'(b_bus),       128'(mb));
        check("f_bus",       128'(f_bus),       128'(mf));
        check("status",      128'(status),      128'(mst));
        check("retired",     128'(retired),     128'(mret));
        check("regs_flat",   128'(regs_flat),   mflat());
      end
    end
  end

  function automatic logic [CWW-1:0] mk(input logic [4:0] fs, input logic wr, input logic [2:0] da,
                                        input logic [2:0] sa, input logic [2:0] sb);
    return {fs, wr, da, sa, sb};
  endfunction

  function automatic logic [CWW-1:0] ldi(input logic [2:0] da, input logic [5:0] v);
    return {5'd31, 1'b1, da, v};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [CWW-1:0] cw);
    cw_in = cw;
    cw_push = 1'b1;
    tick();
    cw_push = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic exec_one(input logic [CWW-1:0] cw);
    push(cw);
    pulse_step();
    repeat (3) tick();
  endtask

  task automatic wait_idle(input int max_cyc, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while ((busy || !cw_empty) && n < max_cyc);
    check("wait_idle_timeout", 128'(busy || !cw_empty), 128'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2 reset_n = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    lit("rst_empty",   128'(cw_empty),    128'(mq.size() == 0), 128'(1));
    lit("rst_full",    128'(cw_full),     128'(mq.size() == FD), 128'(0));
    lit("rst_busy",    128'(busy),        128'(phase != 0), 128'(0));
    lit("rst_retired", 128'(retired),     128'(mret), 128'(0));

    // single step of LDI R1 = 0x2A
    exec_one(ldi(3'd1, 6'h2A));
    lit("step_r1",      128'(dreg(1)), 128'(mregs[1]), 128'(16'h002A));
    lit("step_status",  128'(status),  128'(mst),      128'(4'b0000));
    lit("step_retired", 128'(retired), 128'(mret),     128'(1));
    lit("step_busy",    128'(busy),    128'(phase != 0), 128'(0));

    // back-to-back run of four words
    push(ldi(3'd1, 6'h3F));
    push(ldi(3'd2, 6'h01));
    push(mk(5'd2, 1'b1, 3'd3, 3'd1, 3'd2));
    push(mk(5'd3, 1'b1, 3'd4, 3'd2, 3'd1));
    run = 1'b1;
    wait_idle(40, cyc);
    run = 1'b0;
    // one IDLE->LOAD edge, then three edges per word
    check("run_cycles", 128'(cyc), 128'(13));
    lit("run_r3",     128'(dreg(3)), 128'(mregs[3]), 128'(16'h0040));
    lit("run_r4",     128'(dreg(4)), 128'(mregs[4]), 128'(16'hFFC2));
    lit("run_status", 128'(status),  128'(mst),      128'(4'b0010));

    // NOT, shifts and increment boundaries
    exec_one(mk(5'd7, 1'b1, 3'd6, 3'd0, 3'd0));
    lit("not_f",   128'(f_bus),  128'(mf),  128'(16'hFFFF));
    lit("not_st",  128'(status), 128'(mst), 128'(4'b0010));
    exec_one(mk(5'd9, 1'b1, 3'd1, 3'd0, 3'd6));
    lit("shr_f",   128'(f_bus),  128'(mf),  128'(16'h7FFF));
    lit("shr_st",  128'(status), 128'(mst), 128'(4'b0100));
    exec_one(mk(5'd1, 1'b1, 3'd1, 3'd1, 3'd0));
    lit("inc_ovf_f",  128'(f_bus),  128'(mf),  128'(16'h8000));
    lit("inc_ovf_st", 128'(status), 128'(mst), 128'(4'b1010));
    exec_one(mk(5'd1, 1'b1, 3'd7, 3'd6, 3'd0));
    lit("inc_wrap_f",  128'(f_bus),  128'(mf),  128'(16'h0000));
    lit("inc_wrap_st", 128'(status), 128'(mst), 128'(4'b0101));
    exec_one(mk(5'd8, 1'b1, 3'd5, 3'd0, 3'd6));
    lit("shl_f",   128'(f_bus),  128'(mf),  128'(16'hFFFE));
    lit("shl_st",  128'(status), 128'(mst), 128'(4'b0110));
    lit("t4_retired", 128'(retired), 128'(mret), 128'(10));

    // push into a full queue on the same edge as the LOAD pop
    push(ldi(3'd2, 6'd1));
    push(ldi(3'd3, 6'd2));
    push(ldi(3'd4, 6'd3));
    push(ldi(3'd5, 6'd4));
    lit("fill_full", 128'(cw_full), 128'(mq.size() == FD), 128'(1));
    pulse_step();
    push(ldi(3'd6, 6'd5));
    lit("pop_push_ovf",  128'(cw_overflow), 128'(movf), 128'(0));
    lit("pop_push_full", 128'(cw_full), 128'(mq.size() == FD), 128'(1));
    run = 1'b1;
    wait_idle(60, cyc);
    run = 1'b0;
    lit("pop_push_r6",      128'(dreg(6)), 128'(mregs[6]), 128'(16'h0005));
    lit("pop_push_retired", 128'(retired), 128'(mret), 128'(15));

    // five pushes with no execution: the fifth is dropped
    push(ldi(3'd2, 6'h21));
    push(ldi(3'd3, 6'h22));
    push(ldi(3'd4, 6'h23));
    push(ldi(3'd5, 6'h24));
    lit("ovf_full4", 128'(cw_full), 128'(mq.size() == FD), 128'(1));
    lit("ovf_pre",   128'(cw_overflow), 128'(movf), 128'(0));
    push(ldi(3'd6, 6'h25));
    lit("ovf_set",   128'(cw_overflow), 128'(movf), 128'(1));
    run = 1'b1;
    wait_idle(60, cyc);
    run = 1'b0;
    lit("ovf_retired", 128'(retired), 128'(mret), 128'(19));
    lit("ovf_r5",      128'(dreg(5)), 128'(mregs[5]), 128'(16'h0024));
    lit("ovf_r6",      128'(dreg(6)), 128'(mregs[6]), 128'(16'h0005));

    // run drops during EXEC of the second of three words
    push(ldi(3'd1, 6'h11));
    push(ldi(3'd2, 6'h12));
    push(ldi(3'd3, 6'h13));
    run = 1'b1;
    repeat (5) tick();
    run = 1'b0;
    repeat (4) tick();
    lit("drop_retired", 128'(retired), 128'(mret), 128'(21));
    lit("drop_busy",    128'(busy), 128'(phase != 0), 128'(0));
    lit("drop_empty",   128'(cw_empty), 128'(mq.size() == 0), 128'(0));
    lit("drop_r2",      128'(dreg(2)), 128'(mregs[2]), 128'(16'h0012));
    lit("drop_r3",      128'(dreg(3)), 128'(mregs[3]), 128'(16'h0022));

    // reset asserted while the third word sits in WB
    pulse_step();
    tick();
    tick();
    #1 reset_n = 1'b0;
    #1;
    lit("wbrst_regs",    regs_flat, mflat(), 128'(0));
    lit("wbrst_retired", 128'(retired), 128'(mret), 128'(0));
    lit("wbrst_busy",    128'(busy), 128'(phase != 0), 128'(0));
    lit("wbrst_empty",   128'(cw_empty), 128'(mq.size() == 0), 128'(1));
    lit("wbrst_ovf",     128'(cw_overflow), 128'(movf), 128'(0));
    lit("wbrst_cur",     128'(cur_cw), 128'(mcur), 128'(0));
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (2) tick();
    lit("wbrst_r3_after", 128'(dreg(3)), 128'(mregs[3]), 128'(0));

    // LDI to R0
    exec_one(ldi(3'd0, 6'h15));
    lit("r0_value",   128'(dreg(0)), 128'(mregs[0]), R0Z ? 128'(0) : 128'(16'h0015));
    lit("r0_retired", 128'(retired), 128'(mret), 128'(1));
    lit("r0_status",  128'(status),  128'(mst),  128'(4'b0000));
    lit("r0_f",       128'(f_bus),   128'(mf),   128'(16'h0015));

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
